// File: rtl/softmax_max_subtract.sv
`default_nettype none
// ============================================================================
// softmax_max_subtract : buffers one score vector, then streams x[i] - max(x)
// Revision 1.0 - initial release
// ============================================================================
module softmax_max_subtract #(
  parameter int VEC_LEN = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [DATA_W-1:0] vec_max
);

  localparam int                 C_IDX_W    = ($clog2(VEC_LEN) < 1) ? 1 : $clog2(VEC_LEN);
  localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(VEC_LEN - 1);
  localparam logic [DATA_W-1:0]  C_NEG_FS   = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [0:0] S_LOAD = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_next_state;
  logic [C_IDX_W-1:0] r_idx;
  logic [DATA_W-1:0]  r_max;
  logic [DATA_W-1:0]  r_buf [VEC_LEN];
  logic               w_accept;
  logic               w_idx_last;
  logic [DATA_W-1:0]  w_new_max;
  logic [DATA_W:0]    w_diff;
  logic [DATA_W-1:0]  w_sat;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOAD: if (w_accept && w_idx_last) w_next_state = S_EMIT;
      S_EMIT: if (w_idx_last) w_next_state = S_LOAD;
      default: w_next_state = S_LOAD;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (r_state == S_LOAD);
  end

  assign w_accept   = in_valid && in_ready;
  assign w_idx_last = (r_idx == C_LAST_IDX);

  // First element of a vector seeds the running max; ties keep the old value.
  assign w_new_max = ((r_idx == '0) || ($signed(in_data) > $signed(r_max))) ? in_data : r_max;

  // The difference is never positive, so only negative overflow needs clamping.
  assign w_diff = {r_buf[r_idx][DATA_W-1], r_buf[r_idx]} - {vec_max[DATA_W-1], vec_max};
  assign w_sat  = (w_diff[DATA_W] && !w_diff[DATA_W-1]) ? C_NEG_FS : w_diff[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (w_accept || (r_state == S_EMIT)) begin
      r_idx <= w_idx_last ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max   <= '0;
      vec_max <= '0;
    end else if (w_accept) begin
      r_max <= w_new_max;
      if (w_idx_last) begin
        vec_max <= w_new_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_idx] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (r_state == S_EMIT) begin
      out_valid <= 1'b1;
      out_last  <= w_idx_last;
      out_data  <= w_sat;
    end else begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule
`default_nettype wire
